// File: rtl/vga_if.sv
// VGA pixel stream bundle: raster counters, sync/blank strobes and 12-bit colour.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_sprite_layer.sv
// Sprite overlay stage: per-frame latched position/scale, external sync ROM fetch.
// Optional colour-key transparency is enabled by defining SPRITE_COLORKEY_EN.
module draw_sprite_layer #(
    parameter int          SPR_W   = 48,
    parameter int          SPR_H   = 64,
    parameter int          ROM_LAT = 1,
    parameter int          ADDR_W  = $clog2(SPR_W * SPR_H),
    parameter logic [11:0] KEY_RGB = 12'hF0F
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_if.slave              vga_in,
    vga_if.master             vga_out,
    input  logic              en_i,
    input  logic [11:0]       xpos_i,
    input  logic [11:0]       ypos_i,
    input  logic              scale2_i,
    output logic [ADDR_W-1:0] pixel_addr_o,
    input  logic [11:0]       rgb_pixel_i
);

    localparam int D = ROM_LAT + 1;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
        logic        hit;
    } stage_t;

    stage_t            pipe_q [D];
    logic              vsync_q;
    logic [11:0]       ax_q, ay_q;
    logic              as_q, aen_q, armed_q;
    logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;

    logic              vs_rise;
    logic [12:0]       hc, vc, ax13, ay13, dx, dy, sw, sh, col, row;
    logic              hit;
    logic              draw;
    stage_t            stage_in;

    assign vs_rise = vga_in.vsync & ~vsync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            ax_q    <= '0;
            ay_q    <= '0;
            as_q    <= 1'b0;
            aen_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            vsync_q <= vga_in.vsync;
            if (vs_rise) begin
                ax_q    <= xpos_i;
                ay_q    <= ypos_i;
                as_q    <= scale2_i;
                aen_q   <= en_i;
                armed_q <= 1'b1;
            end
        end
    end

    // 13-bit arithmetic keeps ax/ay near 4095 from wrapping into the visible area.
    always_comb begin
        hc   = {2'b00, vga_in.hcount};
        vc   = {2'b00, vga_in.vcount};
        ax13 = {1'b0, ax_q};
        ay13 = {1'b0, ay_q};
        dx   = hc - ax13;
        dy   = vc - ay13;
        sw   = 13'(SPR_W) << as_q;
        sh   = 13'(SPR_H) << as_q;
        col  = dx >> as_q;
        row  = dy >> as_q;
        hit  = armed_q & aen_q & ~vga_in.hblnk & ~vga_in.vblnk
             & (hc >= ax13) & (dx < sw) & (vc >= ay13) & (dy < sh);
        pixel_addr_d = pixel_addr_q;
        if (hit) begin
            pixel_addr_d = ADDR_W'(32'(row) * 32'(SPR_W) + 32'(col));
        end
    end

    always_comb begin
        stage_in.hcount = vga_in.hcount;
        stage_in.vcount = vga_in.vcount;
        stage_in.hsync  = vga_in.hsync;
        stage_in.vsync  = vga_in.vsync;
        stage_in.hblnk  = vga_in.hblnk;
        stage_in.vblnk  = vga_in.vblnk;
        stage_in.rgb    = vga_in.rgb;
        stage_in.hit    = hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_addr_q <= '0;
            for (int i = 0; i < D; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pixel_addr_q <= pixel_addr_d;
            pipe_q[0]    <= stage_in;
            for (int i = 1; i < D; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign pixel_addr_o = pixel_addr_q;

`ifdef SPRITE_COLORKEY_EN
    assign draw = pipe_q[D-1].hit & (rgb_pixel_i != KEY_RGB);
`else
    logic unused_key;
    assign unused_key = ^KEY_RGB;
    assign draw = pipe_q[D-1].hit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.hcount <= pipe_q[D-1].hcount;
            vga_out.vcount <= pipe_q[D-1].vcount;
            vga_out.hsync  <= pipe_q[D-1].hsync;
            vga_out.vsync  <= pipe_q[D-1].vsync;
            vga_out.hblnk  <= pipe_q[D-1].hblnk;
            vga_out.vblnk  <= pipe_q[D-1].vblnk;
            vga_out.rgb    <= draw ? rgb_pixel_i : pipe_q[D-1].rgb;
        end
    end

endmodule

// File: tb/tb_draw_sprite_layer.sv
// Randomised bench for draw_sprite_layer against a per-pixel geometric reference model.
module tb_draw_sprite_layer;

    localparam int ROM_LAT = 1;
    localparam int L       = ROM_LAT + 2;
    localparam int SPR_W   = 48;
    localparam int SPR_H   = 64;
    localparam int ADDR_W  = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rst_req = 1'b0;
    logic              en_i = 1'b1;
    logic [11:0]       xpos_i = '0;
    logic [11:0]       ypos_i = '0;
    logic              scale2_i = 1'b0;
    logic [ADDR_W-1:0] pixel_addr_o;
    logic [11:0]       rgb_pixel_i;
    logic [11:0]       rom_sr [ROM_LAT];

    vga_if vin ();
    vga_if vout ();

    always #5 clk = ~clk;

    draw_sprite_layer #(.SPR_W(SPR_W), .SPR_H(SPR_H), .ROM_LAT(ROM_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vga_in       (vin),
        .vga_out      (vout),
        .en_i         (en_i),
        .xpos_i       (xpos_i),
        .ypos_i       (ypos_i),
        .scale2_i     (scale2_i),
        .pixel_addr_o (pixel_addr_o),
        .rgb_pixel_i  (rgb_pixel_i)
    );

    // ROM contents: address as colour, except word 5 holds the key colour.
    function automatic logic [11:0] rom_f(input int a);
        return (a == 5) ? 12'hF0F : 12'(a);
    endfunction

    always @(posedge clk) begin
        rom_sr[0] <= rom_f(int'(pixel_addr_o));
        for (int i = 1; i < ROM_LAT; i++) rom_sr[i] <= rom_sr[i-1];
    end
    assign rgb_pixel_i = rom_sr[ROM_LAT-1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    logic [37:0] hist [$];
    int  m_ax = 0, m_ay = 0, m_as = 0, m_addr = 0;
    bit  m_aen = 0, m_armed = 0, m_pvs = 0;

    function automatic logic [37:0] obs_bus();
        return {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};
    endfunction

    task automatic drive(input int h, input int v, input bit hs, input bit vs,
                         input bit hb, input bit vb, input logic [11:0] rgb);
        int sw, sh, a;
        bit hit;
        logic [11:0] e_rgb, rv;
        @(negedge clk);
        if (hist.size() == L) check("bus", obs_bus(), hist.pop_front());
        check("addr", 38'(pixel_addr_o), 38'(m_addr));
        if (rst_n && !rst_req) begin
            rst_n = 1'b0;
            #1;
            check("rst_bus", obs_bus(), '0);
            check("rst_addr", 38'(pixel_addr_o), '0);
            hist.delete();
            repeat (L - 1) hist.push_back('0);
            m_ax = 0; m_ay = 0; m_as = 0; m_aen = 0; m_armed = 0; m_addr = 0;
        end else if (!rst_n && rst_req) begin
            rst_n = 1'b1;
        end
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hsync  = hs;
        vin.vsync  = vs;
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.rgb    = rgb;
        if (!rst_n) begin
            hist.push_back('0);
            m_pvs = 0;
        end else begin
            sw  = SPR_W << m_as;
            sh  = SPR_H << m_as;
            hit = m_armed && m_aen && !hb && !vb && h >= m_ax && h < m_ax + sw
                  && v >= m_ay && v < m_ay + sh;
            e_rgb = rgb;
            if (hit) begin
                a = ((v - m_ay) >> m_as) * SPR_W + ((h - m_ax) >> m_as);
                m_addr = a;
                rv = rom_f(a);
`ifdef SPRITE_COLORKEY_EN
                e_rgb = (rv == 12'hF0F) ? rgb : rv;
`else
                e_rgb = rv;
`endif
            end
            hist.push_back({11'(h), 11'(v), hs, vs, hb, vb, e_rgb});
            if (vs && !m_pvs) begin
                m_ax = int'(xpos_i); m_ay = int'(ypos_i); m_as = int'(scale2_i);
                m_aen = en_i; m_armed = 1;
            end
            m_pvs = vs;
        end
    endtask

    task automatic pix(input int h, input int v);
        drive(h, v, 1'($urandom), 1'b0, h >= 800, v >= 600, 12'($urandom));
    endtask

    task automatic rnd_pix(input int n, input int hlo, input int hw, input int vlo, input int vh);
        int h, v;
        for (int i = 0; i < n; i++) begin
            h = hlo + $urandom_range(0, hw - 1);
            v = vlo + $urandom_range(0, vh - 1);
            if (h > 1055) h = 1055;
            if (v > 627) v = 627;
            pix(h, v);
        end
    endtask

    task automatic vsync_seq(input int x, input int y, input bit s, input bit e);
        xpos_i = 12'(x); ypos_i = 12'(y); scale2_i = s; en_i = e;
        drive(0, 600, 0, 0, 1, 1, 12'($urandom));
        drive(0, 601, 0, 0, 1, 1, 12'($urandom));
        drive(0, 602, 0, 1, 1, 1, 12'($urandom));
        drive(1, 602, 0, 1, 1, 1, 12'($urandom));
        drive(0, 603, 0, 0, 1, 1, 12'($urandom));
    endtask

    initial begin
        int x, y;
        for (int i = 0; i < L - 1; i++) hist.push_back('0);

        rnd_pix(5, 0, 60, 0, 70);
        rst_req = 1'b1;
        rnd_pix(60, 0, 60, 0, 70);

        vsync_seq(100, 50, 0, 1);
        pix(100, 50); pix(147, 113); pix(99, 50); pix(148, 50);
        pix(147, 114); pix(100, 49); pix(105, 50); pix(120, 80);
        rnd_pix(300, 80, 100, 40, 90);

        vsync_seq(100, 50, 1, 1);
        pix(100, 50); pix(101, 51); pix(100, 51); pix(195, 177);
        pix(196, 177); pix(195, 178); pix(99, 60);
        rnd_pix(300, 90, 120, 40, 150);

        vsync_seq(780, 580, 0, 1);
        pix(780, 580); pix(799, 599); pix(779, 580); pix(780, 579); pix(800, 580);
        rnd_pix(300, 740, 316, 540, 88);

        vsync_seq(4090, 580, 0, 1);
        pix(0, 580); pix(0, 0); pix(799, 599);
        rnd_pix(150, 0, 1056, 0, 628);

        vsync_seq(100, 170, 0, 1);
        rnd_pix(150, 80, 320, 150, 50);
        xpos_i = 12'd300;
        rnd_pix(150, 80, 320, 200, 60);
        vsync_seq(300, 170, 0, 1);
        rnd_pix(200, 80, 320, 150, 110);

        vsync_seq(100, 50, 0, 0);
        rnd_pix(100, 80, 100, 40, 90);

        vsync_seq(100, 50, 0, 1);
        rnd_pix(40, 90, 70, 40, 80);
        rst_req = 1'b0;
        rnd_pix(3, 90, 70, 40, 80);
        rst_req = 1'b1;
        rnd_pix(60, 90, 70, 40, 80);

        for (int f = 0; f < 6; f++) begin
            x = $urandom_range(0, 820);
            y = $urandom_range(0, 620);
            vsync_seq(x, y, 1'($urandom), ($urandom_range(0, 4) != 0));
            rnd_pix(200, (x > 20) ? x - 20 : 0, 140, (y > 20) ? y - 20 : 0, 170);
        end

        for (int i = 0; i < L; i++) drive(0, 600, 0, 0, 1, 1, 12'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
